// File: rtl/sp_mem_pkg.sv
// ----------------------------------------------------------------------------
// sp_mem_pkg
// Shared constants and types for the ShortestPath memory subsystem.
//   DEF_A_WIDTH / DEF_D_WIDTH : SRAM address / data widths
//   DEF_N_REQ                 : default number of SRAM requesters
//   RW_READ / RW_WRITE        : encoding of the SRAM RW pin
//   state_e                   : arbiter state (IDLE, OWN)
// ----------------------------------------------------------------------------
package sp_mem_pkg;

    localparam int unsigned DEF_A_WIDTH = 13;
    localparam int unsigned DEF_D_WIDTH = 8;
    localparam int unsigned DEF_N_REQ   = 3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set bit of i_req
// searching upward from i_ptr+1 (wrapping), as a one-hot vector.
// Ports:
//   i_req  : request vector
//   i_ptr  : index of the last served requester
//   o_gnt  : one-hot winner (zero when no request)
//   o_any  : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_any
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_hi;
    logic [N_REQ-1:0] w_src;

    always_comb begin
        w_mask = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_mask[j] = (j > int'(i_ptr));
        end
        // Prefer requests above ptr; fall back to the wrapped lower half.
        w_hi  = i_req & w_mask;
        w_src = (|w_hi) ? w_hi : i_req;
        // Isolate the lowest set bit.
        o_gnt = w_src & (~w_src + N_REQ'(1));
        o_any = |i_req;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
// Round-robin arbiter sharing one single-port SRAM between N_REQ requesters,
// with locked ownership and a fairness limit on unlocked bursts.
// Ports:
//   Clk, Rst          : clock (rising edge), async active-low reset
//   Req, Lock, Rw     : per-requester request, lock, direction (1 = write)
//   Addr, Wdata       : packed per-requester address / write data
//   Gnt               : registered one-hot grant (zero when idle)
//   Rvalid, Rdata     : read return, tagged per requester; Rdata = Mem_Rdata
//   Mem_Addr, Mem_Wdata, Mem_Rw, Mem_En : SRAM pins
//   Mem_Rdata         : registered SRAM output
// ----------------------------------------------------------------------------
module sram_port_arbiter
    import sp_mem_pkg::*;
#(
    parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
    parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ-1:0]           Lock,
    input  logic [N_REQ-1:0]           Rw,
    input  logic [N_REQ*A_WIDTH-1:0]   Addr,
    input  logic [N_REQ*D_WIDTH-1:0]   Wdata,
    output logic [N_REQ-1:0]           Gnt,
    output logic [N_REQ-1:0]           Rvalid,
    output logic [D_WIDTH-1:0]         Rdata,
    output logic [A_WIDTH-1:0]         Mem_Addr,
    output logic [D_WIDTH-1:0]         Mem_Wdata,
    input  logic [D_WIDTH-1:0]         Mem_Rdata,
    output logic                       Mem_Rw,
    output logic                       Mem_En
);

    localparam int unsigned PW        = $clog2(N_REQ);
    localparam logic [7:0]  BURST_SAT = 8'(MAX_BURST);
    localparam logic [8:0]  BURST_LIM = 9'(MAX_BURST);

    state_e           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_rvalid;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [7:0]       r_burst, w_burst_nxt;

    logic [N_REQ-1:0] w_sel;
    logic             w_access;
    logic             w_own_lock;
    logic [PW-1:0]    w_own_idx;
    logic             w_limit;

    logic [N_REQ-1:0] w_pick_req;
    logic [PW-1:0]    w_pick_ptr;
    logic [N_REQ-1:0] w_pick_gnt;
    logic             w_pick_any;

    assign w_sel      = r_gnt & Req;
    assign w_access   = |w_sel;
    assign w_own_lock = |(r_gnt & Lock);
    assign w_limit    = (({1'b0, r_burst} + 9'd1) >= BURST_LIM);

    always_comb begin
        w_own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_own_idx = PW'(i);
            end
        end
    end

    // In IDLE r_gnt is zero, so masking is a no-op and ptr is the search base.
    // While owned, the owner is excluded and the search starts past it.
    assign w_pick_req = Req & ~r_gnt;
    assign w_pick_ptr = (r_state == OWN) ? w_own_idx : r_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req (w_pick_req),
        .i_ptr (w_pick_ptr),
        .o_gnt (w_pick_gnt),
        .o_any (w_pick_any)
    );

    // SRAM pin mux, selected by the registered grant.
    always_comb begin
        Mem_En    = 1'b0;
        Mem_Rw    = RW_READ;
        Mem_Addr  = '0;
        Mem_Wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) begin
                Mem_En    = 1'b1;
                Mem_Rw    = Rw[i];
                Mem_Addr  = Addr[i*A_WIDTH +: A_WIDTH];
                Mem_Wdata = Wdata[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = w_pick_gnt;
                end
            end
            OWN: begin
                if (!w_access && !w_own_lock) begin
                    // Release wins over rotation; hand off directly if possible.
                    w_ptr_nxt = w_own_idx;
                    if (w_pick_any) begin
                        w_gnt_nxt = w_pick_gnt;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_access && !w_own_lock && w_limit && w_pick_any) begin
                    w_ptr_nxt = w_own_idx;
                    w_gnt_nxt = w_pick_gnt;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_burst_nxt = r_burst;
        if (w_gnt_nxt != r_gnt) begin
            w_burst_nxt = '0;
        end else if (w_access && (r_burst < BURST_SAT)) begin
            w_burst_nxt = r_burst + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ptr    <= PW'(N_REQ - 1);
            r_burst  <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_burst  <= w_burst_nxt;
            // Tag comes from the issuing cycle, so it survives a handoff.
            r_rvalid <= (Mem_Rw == RW_READ) ? w_sel : '0;
        end
    end

    assign Gnt    = r_gnt;
    assign Rvalid = r_rvalid;
    assign Rdata  = Mem_Rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [2:0]  Req = '0;
    logic [2:0]  Lock = '0;
    logic [2:0]  Rw = '0;
    logic [38:0] Addr = '0;
    logic [23:0] Wdata = '0;
    logic [2:0]  Gnt;
    logic [2:0]  Rvalid;
    logic [7:0]  Rdata;
    logic [12:0] Mem_Addr;
    logic [7:0]  Mem_Wdata;
    logic [7:0]  Mem_Rdata = '0;
    logic        Mem_Rw;
    logic        Mem_En;

    logic [7:0]  sram    [0:8191];
    logic [7:0]  exp_mem [0:8191];
    logic [10:0] sb_q[$];
    logic [10:0] sb_item;
    int          checks = 0;
    int          failures = 0;

    always #5 Clk = ~Clk;

    sram_port_arbiter #(
        .A_WIDTH   (13),
        .D_WIDTH   (8),
        .N_REQ     (3),
        .MAX_BURST (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .Lock      (Lock),
        .Rw        (Rw),
        .Addr      (Addr),
        .Wdata     (Wdata),
        .Gnt       (Gnt),
        .Rvalid    (Rvalid),
        .Rdata     (Rdata),
        .Mem_Addr  (Mem_Addr),
        .Mem_Wdata (Mem_Wdata),
        .Mem_Rdata (Mem_Rdata),
        .Mem_Rw    (Mem_Rw),
        .Mem_En    (Mem_En)
    );

    // Single-port SRAM with registered read output.
    initial begin
        for (int i = 0; i < 8192; i++) sram[i] = 8'(i * 7 + 3);
    end
    always @(posedge Clk) begin
        if (Mem_En) begin
            if (Mem_Rw) sram[Mem_Addr] <= Mem_Wdata;
            else        Mem_Rdata <= sram[Mem_Addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic r, input logic w,
                       input logic [12:0] a, input logic [7:0] d);
        Req[i]           = r;
        Rw[i]            = w;
        Addr[i*13 +: 13] = a;
        Wdata[i*8 +: 8]  = d;
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic exp_rd(input int i, input logic [12:0] a);
        logic [2:0] t;
        t = 3'b001 << i;
        sb_q.push_back({t, exp_mem[a]});
    endtask

    // Scoreboard: every Rvalid pulse must match the oldest expected read.
    always @(negedge Clk) begin
        if (Rvalid !== 3'b000) begin
            if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(Rvalid), 32'h0);
            end else begin
                sb_item = sb_q.pop_front();
                chk("rvalid_tag", 32'(Rvalid), 32'(sb_item[10:8]));
                chk("rdata", 32'(Rdata), 32'(sb_item[7:0]));
            end
        end
    end

    initial begin
        logic rd1;
        logic prev_rd;
        int   o;
        for (int i = 0; i < 8192; i++) exp_mem[i] = 8'(i * 7 + 3);

        // Reset values.
        repeat (3) nxt();
        chk("rst_gnt", 32'(Gnt), 32'h0);
        chk("rst_rvalid", 32'(Rvalid), 32'h0);
        chk("rst_en", 32'(Mem_En), 32'h0);
        chk("rst_rw", 32'(Mem_Rw), 32'h0);
        chk("rst_addr", 32'(Mem_Addr), 32'h0);
        chk("rst_wdata", 32'(Mem_Wdata), 32'h0);
        Rst = 1'b1;

        // Single requester round trip.
        nxt(); drv(0, 1, 1, 13'h01A5, 8'h3C); settle();
        chk("rt_idle_gnt", 32'(Gnt), 32'h0);
        chk("rt_idle_en", 32'(Mem_En), 32'h0);
        nxt(); settle();
        chk("rt_wr_gnt", 32'(Gnt), 32'h1);
        chk("rt_wr_en", 32'(Mem_En), 32'h1);
        chk("rt_wr_rw", 32'(Mem_Rw), 32'h1);
        chk("rt_wr_addr", 32'(Mem_Addr), 32'h01A5);
        chk("rt_wr_data", 32'(Mem_Wdata), 32'h3C);
        exp_mem[13'h01A5] = 8'h3C;
        nxt(); drv(0, 1, 0, 13'h01A5, 8'h00); settle();
        chk("rt_rd_en", 32'(Mem_En), 32'h1);
        chk("rt_rd_rw", 32'(Mem_Rw), 32'h0);
        chk("rt_rd_addr", 32'(Mem_Addr), 32'h01A5);
        exp_rd(0, 13'h01A5);
        nxt(); drv(0, 0, 0, 13'h0, 8'h0); settle();
        chk("rt_rvalid", 32'(Rvalid), 32'h1);
        chk("rt_rel_en", 32'(Mem_En), 32'h0);
        nxt(); settle();
        chk("rt_idle_after", 32'(Gnt), 32'h0);
        chk("rt_rvalid_clr", 32'(Rvalid), 32'h0);

        // Release to IDLE, then a fresh request from req2.
        nxt(); drv(2, 1, 0, 13'h0055, 8'h0); settle();
        chk("r2_idle_gnt", 32'(Gnt), 32'h0);
        nxt(); settle();
        chk("r2_gnt", 32'(Gnt), 32'h4);
        chk("r2_addr", 32'(Mem_Addr), 32'h0055);
        exp_rd(2, 13'h0055);
        nxt(); drv(2, 0, 0, 13'h0, 8'h0); settle();
        chk("r2_rvalid", 32'(Rvalid), 32'h4);
        nxt(); settle();
        chk("r2_idle", 32'(Gnt), 32'h0);

        // Fairness: all three requesting, grants 0,1,2,0 with 4 accesses each.
        nxt();
        for (int i = 0; i < 3; i++) drv(i, 1, 1, 13'(13'h0200 + i), 8'(8'hA0 + i));
        settle();
        chk("fair_idle", 32'(Gnt), 32'h0);
        for (int c = 0; c < 16; c++) begin
            nxt(); settle();
            o = (c / 4) % 3;
            chk("fair_gnt", 32'(Gnt), 32'(3'b001 << o));
            chk("fair_en", 32'(Mem_En), 32'h1);
            chk("fair_addr", 32'(Mem_Addr), 32'(13'h0200 + o));
            exp_mem[13'h0200 + o] = 8'(8'hA0 + o);
        end
        // req1 is next; arm its lock (ignored while req0 still owns).
        Lock[1] = 1'b1;
        drv(2, 0, 0, 13'h0, 8'h0);

        // Lock hold: req1 toggles Req while req0 waits.
        prev_rd = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nxt();
            rd1 = (k % 2 == 0);
            drv(1, rd1, 0, 13'h0201, 8'h0);
            settle();
            chk("lock_gnt", 32'(Gnt), 32'h2);
            chk("lock_en", 32'(Mem_En), 32'(rd1));
            chk("lock_rvalid", 32'(Rvalid), prev_rd ? 32'h2 : 32'h0);
            if (rd1) exp_rd(1, 13'h0201);
            prev_rd = rd1;
        end
        nxt(); Lock[1] = 1'b0; drv(1, 0, 0, 13'h0, 8'h0); settle();
        chk("unlock_gnt", 32'(Gnt), 32'h2);
        chk("unlock_en", 32'(Mem_En), 32'h0);
        nxt(); settle();
        chk("unlock_gnt0", 32'(Gnt), 32'h1);
        chk("unlock_en0", 32'(Mem_En), 32'h1);
        chk("unlock_addr0", 32'(Mem_Addr), 32'h0200);

        // Handoff with a read issued in req2's final owned cycle.
        nxt(); drv(0, 0, 1, 13'h0200, 8'hA0); drv(2, 1, 1, 13'h0300, 8'h77); settle();
        chk("ho_rel_gnt", 32'(Gnt), 32'h1);
        chk("ho_rel_en", 32'(Mem_En), 32'h0);
        nxt(); drv(0, 1, 1, 13'h0011, 8'h99); settle();
        chk("ho_gnt2", 32'(Gnt), 32'h4);
        chk("ho_addr2", 32'(Mem_Addr), 32'h0300);
        exp_mem[13'h0300] = 8'h77;
        for (int c = 0; c < 2; c++) begin
            nxt(); settle();
            chk("ho_gnt2_hold", 32'(Gnt), 32'h4);
        end
        nxt(); drv(2, 1, 0, 13'h0010, 8'h0); settle();
        chk("ho_last_gnt", 32'(Gnt), 32'h4);
        chk("ho_last_rw", 32'(Mem_Rw), 32'h0);
        chk("ho_last_addr", 32'(Mem_Addr), 32'h0010);
        exp_rd(2, 13'h0010);
        nxt(); settle();
        chk("ho_new_gnt", 32'(Gnt), 32'h1);
        chk("ho_new_en", 32'(Mem_En), 32'h1);
        chk("ho_new_rw", 32'(Mem_Rw), 32'h1);
        chk("ho_new_addr", 32'(Mem_Addr), 32'h0011);
        chk("ho_rvalid", 32'(Rvalid), 32'h4);
        exp_mem[13'h0011] = 8'h99;
        drv(2, 0, 0, 13'h0, 8'h0);

        // Async reset mid-burst with a read in flight.
        nxt(); drv(0, 1, 0, 13'h0011, 8'h0); settle();
        chk("pre_rst_gnt", 32'(Gnt), 32'h1);
        chk("pre_rst_rw", 32'(Mem_Rw), 32'h0);
        nxt(); settle();
        chk("pre_rst_rvalid", 32'(Rvalid), 32'h1);
        chk("pre_rst_rdata", 32'(Rdata), 32'(exp_mem[13'h0011]));
        #1 Rst = 1'b0;
        #1;
        chk("arst_gnt", 32'(Gnt), 32'h0);
        chk("arst_rvalid", 32'(Rvalid), 32'h0);
        chk("arst_en", 32'(Mem_En), 32'h0);
        chk("arst_rw", 32'(Mem_Rw), 32'h0);
        chk("arst_addr", 32'(Mem_Addr), 32'h0);
        chk("arst_wdata", 32'(Mem_Wdata), 32'h0);
        nxt(); settle();
        chk("in_rst_rvalid", 32'(Rvalid), 32'h0);
        Rst = 1'b1;
        drv(0, 1, 0, 13'h01A5, 8'h0);
        drv(2, 1, 0, 13'h0010, 8'h0);
        settle();
        chk("post_rst_gnt", 32'(Gnt), 32'h0);
        chk("post_rst_rvalid", 32'(Rvalid), 32'h0);

        // After reset ptr = N_REQ-1, so requester 0 wins over requester 2.
        nxt(); settle();
        chk("first_win_gnt", 32'(Gnt), 32'h1);
        chk("first_win_addr", 32'(Mem_Addr), 32'h01A5);
        chk("first_win_rvalid", 32'(Rvalid), 32'h0);
        exp_rd(0, 13'h01A5);
        nxt(); drv(0, 0, 0, 13'h0, 8'h0); settle();
        chk("fw_rvalid", 32'(Rvalid), 32'h1);
        chk("fw_rel_en", 32'(Mem_En), 32'h0);
        nxt(); settle();
        chk("fw_hand_gnt", 32'(Gnt), 32'h4);
        chk("fw_hand_addr", 32'(Mem_Addr), 32'h0010);
        exp_rd(2, 13'h0010);
        nxt(); drv(2, 0, 0, 13'h0, 8'h0); settle();
        chk("fw2_rvalid", 32'(Rvalid), 32'h4);
        nxt(); settle();
        chk("final_idle", 32'(Gnt), 32'h0);
        nxt(); settle();
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter that shares one single-port `SRAM_Memory` instance between up to `N_REQ` requesters, e.g. the `ShortestPath` engine, a host loader that fills M memory, and a result dumper that reads P memory. It owns the SRAM's `Addr`/`Data_In`/`RW`/`En` pins and returns read data tagged to the requester that issued the read. It supports locked bursts and a fairness limit on unlocked ownership.

## Interface

**Parameters**
- `A_WIDTH`, 13: SRAM address width.
- `D_WIDTH`, 8: SRAM data width.
- `N_REQ`, 3: number of requesters (2..8).
- `MAX_BURST`, 16: accesses allowed per unlocked grant while others wait (1..255).

**Ports**
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: asynchronous, active-low reset.
- `Req`  in  N_REQ: per-requester access request, held until the access completes.
- `Lock`  in  N_REQ: owner keeps the grant regardless of `Req` and `MAX_BURST`.
- `Rw`  in  N_REQ: 1 = write, 0 = read.
- `Addr`  in  N_REQ*A_WIDTH: packed addresses; requester i uses slice i.
- `Wdata`  in  N_REQ*D_WIDTH: packed write data.
- `Gnt`  out  N_REQ: registered, one-hot or zero.
- `Rvalid`  out  N_REQ: one-hot pulse; `Rdata` is valid for that requester.
- `Rdata`  out  D_WIDTH: shared read data, passed through from `Mem_Rdata`.
- `Mem_Addr`  out  A_WIDTH: to SRAM `Addr`.
- `Mem_Wdata`  out  D_WIDTH: to SRAM `Data_In`.
- `Mem_Rdata`  in  D_WIDTH: from SRAM `Data_Out`.
- `Mem_Rw`  out  1: to SRAM `RW`; 1 = write.
- `Mem_En`  out  1: to SRAM `En`.

## Operation

- **States:** IDLE (`Gnt`=0) and OWN(i) (`Gnt[i]`=1).
- **Access:** an access occurs in every cycle where `Gnt[i] & Req[i]`.
  - `Mem_En`=1 and `Mem_Addr`/`Mem_Wdata`/`Mem_Rw` are muxed from slice i; the mux select is registered `Gnt`.
  - No access in a cycle: `Mem_En`=0, `Mem_Rw`=0, `Mem_Addr`=0, `Mem_Wdata`=0.
- **IDLE → OWN(w):** taken when any `Req` is high. w is the first requester with `Req` high, searching from `ptr+1` mod `N_REQ`.
- **OWN(i) release:** when `Req[i]`=0 and `Lock[i]`=0.
  - Next state is OWN(w) if another `Req` is pending (direct handoff, no bubble cycle), else IDLE.
  - `ptr` ← i.
- **Fairness:** `burst_cnt` counts accesses in the current grant and clears on any grant change. When `burst_cnt` reaches `MAX_BURST` on an access cycle, `Lock[i]`=0, and any other `Req` is high, the grant rotates to the next winner next cycle.
- **Lock:** `Lock[i]` holds OWN(i) even with `Req[i]`=0; idle locked cycles have `Mem_En`=0. `Lock` from a non-owner is ignored.
- **Reads:** a read access in cycle t sets `Rvalid[i]` in cycle t+1, with `Rdata`=`Mem_Rdata` (registered SRAM output). Read tagging is independent of `Gnt`: a read issued in the last owned cycle still returns to its issuer after handoff.
- **Writes:** no completion signal; the write is done in the access cycle.

## Timing

- **Reset (async, `Rst`=0):** `Gnt`=0, `Rvalid`=0, `Mem_En`=0, `Mem_Rw`=0, `Mem_Addr`=0, `Mem_Wdata`=0, `ptr`=N_REQ-1 (so requester 0 wins first), `burst_cnt`=0.
  - `Rdata` follows `Mem_Rdata` combinationally at all times; it is meaningful only with `Rvalid`.
  - A read in flight at reset is dropped: no `Rvalid` after release.
- **Latency from IDLE:** `Req` in cycle 0 → `Gnt` and access in cycle 1 → `Rvalid` in cycle 2.
- **Throughput:** one access per cycle while owned.
- **Simultaneous events:**
  - Release and rotation are evaluated on the same edge; release takes precedence.
  - `Req` rising at the edge that deasserts `Gnt` is handled through normal arbitration.
- **Counter width:** `burst_cnt` is 8 bits and saturates at `MAX_BURST`.

## Structure

- **Package `sp_mem_pkg`:** `A_WIDTH`, `D_WIDTH`, the default `N_REQ`, the RW encoding constants (`RW_READ`=0, `RW_WRITE`=1), and the state enum `{IDLE, OWN}`.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the request vector and `ptr`; output is a one-hot winner plus a `any` flag.

## Test plan

- **Async reset:** assert `Rst`=0 mid-burst → all outputs at their reset values in the same cycle; no `Rvalid` afterwards.
- **Single requester round trip:** req0 writes `Addr` 0x01A5 ← 0x3C, then reads 0x01A5.
  - Write: `Gnt`=3'b001 one cycle after `Req`; `Mem_En`=1, `Mem_Rw`=1, `Mem_Addr`=0x01A5.
  - Read: `Rvalid`=3'b001 with `Rdata`=0x3C the cycle after the read access.
- **Fairness rotation:** all three `Req` held high, `MAX_BURST`=4, no `Lock` → grants 0,1,2,0 with 4 accesses each and no cycle with `Mem_En`=0.
- **Lock hold:** req1 owns with `Lock`=1 and `Req` toggling while req0 waits 10 cycles.
  - `Gnt` stays 3'b010; `Mem_En`=0 on `Req[1]`=0 cycles.
  - `Lock[1]` and `Req[1]` drop → `Gnt`=3'b001 next cycle.
- **Handoff with pending read:** req2 reads 0x0010 in its final owned cycle while req0 waits → next cycle `Gnt`=3'b001 and req0 write issued, with `Rvalid`=3'b100 and `Rdata`=M[0x0010] in that same cycle.
- **Release to IDLE:** the only owner drops `Req` → `Gnt`=0 next cycle; a new `Req` from req2 → `Gnt`=3'b100 the following cycle.
